// File: rtl/chan_mux_rr_if.sv
// Handshake/data bundle for chan_mux_rr: per-channel input bus, the
// select controls and the registered output port.
// CHAN_MUX_RR_PARITY_EN adds the registered parity bit out_par.
interface chan_mux_rr_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
);
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [N_CH*WIDTH-1:0]   in_data;
  logic [N_CH-1:0]         in_valid;
  logic [N_CH-1:0]         in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_chan;
  logic                    out_valid;
  logic                    out_ready;
`ifdef CHAN_MUX_RR_PARITY_EN
  logic                    out_par;

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_chan, out_valid, out_par
  );
  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_chan, out_valid, out_par
  );
`else
  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );
  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );
`endif
endinterface

// File: rtl/chan_mux_rr.sv
// chan_mux_rr: registered N-channel valid/ready multiplexer with a fixed
// select mode and a fair round-robin mode. One output register stage.
// Optional: define CHAN_MUX_RR_PARITY_EN to add out_par (XOR of out_data).
module chan_mux_rr #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  chan_mux_rr_if.slave  bus
);
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [WIDTH-1:0] ch_data [N_CH];
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] gnt;
  logic             gnt_vld;
  logic             load;
  logic             xfer;
  logic [N_CH-1:0]  rdy;

  logic [WIDTH-1:0] data_p0;
  logic [SEL_W-1:0] chan_p0;
  logic             vld_p0;
`ifdef CHAN_MUX_RR_PARITY_EN
  logic             par_p0;
`endif

  function automatic logic even_par(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign ch_data[i] = bus.in_data[i*WIDTH +: WIDTH];
  end

  // Output register can take a new word when empty or being drained.
  assign load = !vld_p0 || bus.out_ready;

  // Pick at most one candidate: external select, or first valid channel from ptr.
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = 0;
    if (!bus.mode) begin
      if (N_CH == 1) begin
        gnt_vld = 1'b1;
      end else if (int'(bus.sel) < N_CH) begin
        gnt_vld = 1'b1;
        gnt     = bus.sel;
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= N_CH) idx = idx - N_CH;
        if (!gnt_vld && bus.in_valid[SEL_W'(idx)]) begin
          gnt_vld = 1'b1;
          gnt     = SEL_W'(idx);
        end
      end
    end
  end

  // Ready only toward the granted channel, and only when the register can load.
  always_comb begin
    rdy = '0;
    if (gnt_vld && load && !rst) rdy[gnt] = 1'b1;
  end

  assign bus.in_ready = rdy;
  assign xfer         = gnt_vld && load && !rst && bus.in_valid[gnt];

  // Stage p0: output register and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      chan_p0 <= '0;
      ptr_q   <= '0;
`ifdef CHAN_MUX_RR_PARITY_EN
      par_p0  <= 1'b0;
`endif
    end else if (load) begin
      vld_p0 <= xfer;
      if (xfer) begin
        data_p0 <= ch_data[gnt];
        chan_p0 <= gnt;
`ifdef CHAN_MUX_RR_PARITY_EN
        par_p0  <= even_par(ch_data[gnt]);
`endif
        if (bus.mode && N_CH > 1)
          ptr_q <= (gnt == SEL_W'(N_CH - 1)) ? '0 : gnt + SEL_W'(1);
      end
    end
  end

  assign bus.out_data  = data_p0;
  assign bus.out_chan  = chan_p0;
  assign bus.out_valid = vld_p0;
`ifdef CHAN_MUX_RR_PARITY_EN
  assign bus.out_par   = par_p0;
`endif
endmodule

// File: doc/chan_mux_rr.md
Name: chan_mux_rr

Overview:
- Parametrised, registered N-channel multiplexer. Successor to the combinational 4:1 bit mux.
- Each input channel and the single output use a valid/ready handshake. The output has one register stage.
- Two selection modes:
  - Fixed: an external select chooses the channel, as before.
  - Round-robin: a fair arbiter chooses among the channels that have valid data.
- Used wherever several producers share one downstream consumer.

Parameters:
- N_CH, 4, number of input channels (>=1).
- WIDTH, 8, data bits per channel (>=1).
- SEL_W, derived localparam = (N_CH>1) ? $clog2(N_CH) : 1. Not overridable.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SEL_W  channel index used in fixed mode.
- in_data  in  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N_CH  per-channel valid.
- in_ready  out  N_CH  per-channel ready (combinational).
- out_data  out  WIDTH  registered data.
- out_chan  out  SEL_W  index of the channel that produced out_data.
- out_valid  out  1  registered valid.
- out_ready  in  1  downstream ready.

Behaviour:
- Interface decision: one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at an edge):
  - out_valid=0, out_data=0, out_chan=0, rr pointer ptr=0.
  - While rst=1, in_ready=0 on all channels.
  - A reset mid-transfer discards the held output word.
- load = !out_valid || out_ready. The register is empty or being drained this cycle.
- Grant selection (combinational, one channel at most):
  - Fixed mode: candidate = sel.
    - If sel >= N_CH, no grant.
    - in_ready[sel] = load; in_ready is independent of in_valid.
  - Round-robin mode: scan channels ptr, ptr+1, … wrapping modulo N_CH.
    - The first channel with in_valid=1 is granted.
    - in_ready[g] = load for the granted channel only.
    - With no valid channel, no grant and all in_ready=0.
  - All non-granted in_ready are 0.
- Transfer when in_valid[g] && in_ready[g]. On the next edge: out_data <= channel g data, out_chan <= g, out_valid <= 1.
- If load=1 and no transfer occurs, out_valid <= 0 on the next edge.
- If load=0 (out_valid=1, out_ready=0), out_data, out_chan and out_valid hold unchanged. No input is accepted.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 word/cycle when out_ready is held high.
- rr pointer:
  - On a round-robin transfer from g: ptr <= (g==N_CH-1) ? 0 : g+1.
  - Otherwise ptr holds.
  - A fixed-mode transfer does not change ptr.
- mode and sel are sampled combinationally each cycle and take effect the same cycle. Changing them while the output is stalled does not affect the held word.
- N_CH=1: sel is ignored. Channel 0 is always the candidate; ptr stays 0.
- No data is lost or duplicated under any out_ready pattern.

Optional Feature:
- Macro CHAN_MUX_RR_PARITY_EN.
- When defined:
  - Adds output port out_par (out, 1), the even parity (XOR-reduce) of the data word, registered together with out_data.
  - Reset value 0. Holds with out_data during a stall.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset and fixed mode:
  - Stimulus: rst 2 cycles; mode=0, sel=2, in_valid=4'b0100, ch2=8'hA5, out_ready=1.
  - Response: during reset, outputs are 0 and in_ready=0. in_ready=4'b0100. The next cycle out_valid=1, out_data=A5, out_chan=2.
- Fixed mode, unselected valid:
  - Stimulus: sel=1, in_valid=4'b1001.
  - Response: in_ready=4'b0010. No transfer; out_valid drops to 0 the cycle after the last transfer.
- Round-robin fairness:
  - Stimulus: mode=1, all in_valid=1, out_ready=1 for 8 cycles.
  - Response: out_chan sequence 0,1,2,3,0,1,2,3; one word per cycle.
- Round-robin skip and wrap:
  - Stimulus: ptr=0, in_valid=4'b1000, then 4'b0101.
  - Response: channel 3 is granted, then ptr=0. Channel 0 is granted next, then channel 2.
- Backpressure:
  - Stimulus: out_valid=1 with data 8'h3C; out_ready=0 for 3 cycles while inputs are valid.
  - Response: in_ready=0, out_data stays 3C, ptr is unchanged. On the cycle out_ready=1, the next word is accepted and appears one cycle later.
- Parity and mid-op reset (macro defined):
  - Stimulus: data 8'h07, then assert rst while out_valid=1.
  - Response: out_par=1 with data 07. After reset, out_valid=0, out_par=0, ptr=0.
